// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the SRAM port arbiter.
package sram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2
  } arb_state_t;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  // Index width for an N-entry selector; never below one bit.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sram_port_arbiter_if.sv
// Video, writer and sram_ctrl handshake bundle seen by the arbiter.
interface sram_port_arbiter_if #(
  parameter int unsigned NUM_WR  = 2,
  parameter int unsigned ADDR_W  = 20,
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned COORD_W = 10
);
  logic                       vid_active;
  logic [COORD_W-1:0]         draw_x;
  logic [COORD_W-1:0]         draw_y;
  logic [DATA_W-1:0]          pix_data;
  logic                       pix_valid;
  logic [NUM_WR-1:0]          wr_req;
  logic [NUM_WR*ADDR_W-1:0]   wr_addr;
  logic [NUM_WR*DATA_W-1:0]   wr_data;
  logic [NUM_WR-1:0]          wr_grant;
  logic [NUM_WR-1:0]          wr_done;
  logic                       ctrl_start_n;
  logic                       ctrl_rw;
  logic [ADDR_W-1:0]          ctrl_addr;
  logic [DATA_W-1:0]          ctrl_wdata;
  logic                       ctrl_ready;
  logic [DATA_W-1:0]          ctrl_rdata;
  logic                       busy;
  logic                       err;

  modport master (
    input  vid_active, draw_x, draw_y, wr_req, wr_addr, wr_data, ctrl_ready, ctrl_rdata,
    output pix_data, pix_valid, wr_grant, wr_done, ctrl_start_n, ctrl_rw, ctrl_addr,
           ctrl_wdata, busy, err
  );

  modport slave (
    output vid_active, draw_x, draw_y, wr_req, wr_addr, wr_data, ctrl_ready, ctrl_rdata,
    input  pix_data, pix_valid, wr_grant, wr_done, ctrl_start_n, ctrl_rw, ctrl_addr,
           ctrl_wdata, busy, err
  );
endinterface

// File: rtl/sram_port_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first requester at or after i_ptr, wrapping.
module rr_arbiter
  import sram_arb_pkg::*;
#(
  parameter  int unsigned N     = 2,
  localparam int unsigned IDX_W = idx_w(N)
) (
  input  logic [N-1:0]     i_req,
  input  logic [IDX_W-1:0] i_ptr,
  output logic [N-1:0]     o_gnt,
  output logic [IDX_W-1:0] o_idx
);

  int unsigned      w_dist;
  int unsigned      w_best_dist;
  logic [IDX_W-1:0] w_best;
  logic             w_found;

  // Smallest forward distance from the pointer wins.
  always_comb begin
    w_dist      = 0;
    w_best_dist = N;
    w_best      = '0;
    w_found     = 1'b0;
    for (int unsigned c = 0; c < N; c++) begin
      w_dist = (c >= 32'(i_ptr)) ? (c - 32'(i_ptr)) : (c + N - 32'(i_ptr));
      if (i_req[c] && (w_dist < w_best_dist)) begin
        w_best_dist = w_dist;
        w_best      = IDX_W'(c);
        w_found     = 1'b1;
      end
    end
    o_idx = w_best;
    o_gnt = w_found ? (N'(1) << w_best) : '0;
  end

endmodule

// File: rtl/sram_port_arbiter.sv
// Shares one sram_ctrl port between video reads (priority while active) and
// round-robin writers during blanking, with a stall watchdog.
module sram_port_arbiter
  import sram_arb_pkg::*;
#(
  parameter int unsigned NUM_WR  = 2,
  parameter int unsigned ADDR_W  = 20,
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned COORD_W = 10,
  parameter int unsigned H_RES   = 640,
  parameter int unsigned TIMEOUT = 16
) (
  input logic                 clk,
  input logic                 reset_n,
  sram_port_arbiter_if.master arb_bus
);

  localparam int unsigned IDX_W  = idx_w(NUM_WR);
  localparam int unsigned WAIT_W = $clog2(TIMEOUT + 1);

  arb_state_t          r_state, w_state_nxt;
  logic                r_start_n, w_start_n_nxt;
  logic                r_rw, w_rw_nxt;
  logic [ADDR_W-1:0]   r_addr, w_addr_nxt;
  logic [DATA_W-1:0]   r_wdata, w_wdata_nxt;
  logic [DATA_W-1:0]   r_pix_data, w_pix_nxt;
  logic                r_pix_valid, w_pix_valid_nxt;
  logic [NUM_WR-1:0]   r_grant, w_grant_nxt;
  logic [NUM_WR-1:0]   r_done, w_done_nxt;
  logic                r_busy;
  logic                r_err, w_err_nxt;
  logic [IDX_W-1:0]    r_ptr, w_ptr_nxt;
  logic [IDX_W-1:0]    r_sel, w_sel_nxt;
  logic [WAIT_W-1:0]   r_wait, w_wait_nxt;

  logic [COORD_W-1:0]  w_draw_x, w_draw_y;
  logic [ADDR_W-1:0]   w_pix_addr;
  logic [NUM_WR-1:0]   w_gnt;
  logic [IDX_W-1:0]    w_gnt_idx;
  logic [ADDR_W-1:0]   w_sel_addr;
  logic [DATA_W-1:0]   w_sel_data;
  logic                w_timeout;
  logic [IDX_W-1:0]    w_ptr_adv;

  assign w_draw_x   = arb_bus.draw_x;
  assign w_draw_y   = arb_bus.draw_y;
  // Arithmetic held to ADDR_W bits so the address wraps mod 2^ADDR_W.
  assign w_pix_addr = ADDR_W'(ADDR_W'(w_draw_y) * ADDR_W'(H_RES) + ADDR_W'(w_draw_x));
  assign w_timeout  = (r_wait == WAIT_W'(TIMEOUT - 1));
  assign w_ptr_adv  = (r_sel == IDX_W'(NUM_WR - 1)) ? '0 : (r_sel + IDX_W'(1));

  rr_arbiter #(.N(NUM_WR)) u_rr (
    .i_req (arb_bus.wr_req),
    .i_ptr (r_ptr),
    .o_gnt (w_gnt),
    .o_idx (w_gnt_idx)
  );

  always_comb begin
    w_sel_addr = '0;
    w_sel_data = '0;
    for (int c = 0; c < int'(NUM_WR); c++) begin
      if (w_gnt[c]) begin
        w_sel_addr = arb_bus.wr_addr[c*ADDR_W +: ADDR_W];
        w_sel_data = arb_bus.wr_data[c*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (arb_bus.vid_active)  w_state_nxt = READ;
        else if (|arb_bus.wr_req) w_state_nxt = WRITE;
      end
      READ, WRITE: begin
        if (arb_bus.ctrl_ready || w_timeout) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Next values for every registered output and datapath register.
  always_comb begin
    w_start_n_nxt   = 1'b1;
    w_rw_nxt        = r_rw;
    w_addr_nxt      = r_addr;
    w_wdata_nxt     = r_wdata;
    w_pix_nxt       = r_pix_data;
    w_pix_valid_nxt = 1'b0;
    w_grant_nxt     = '0;
    w_done_nxt      = '0;
    w_err_nxt       = r_err;
    w_ptr_nxt       = r_ptr;
    w_sel_nxt       = r_sel;
    w_wait_nxt      = r_wait;
    case (r_state)
      IDLE: begin
        if (arb_bus.vid_active) begin
          w_start_n_nxt = 1'b0;
          w_rw_nxt      = RW_READ;
          w_addr_nxt    = w_pix_addr;
          w_wait_nxt    = '0;
        end else if (|arb_bus.wr_req) begin
          w_start_n_nxt = 1'b0;
          w_rw_nxt      = RW_WRITE;
          w_addr_nxt    = w_sel_addr;
          w_wdata_nxt   = w_sel_data;
          w_grant_nxt   = w_gnt;
          w_sel_nxt     = w_gnt_idx;
          w_wait_nxt    = '0;
        end
      end
      READ: begin
        if (arb_bus.ctrl_ready) begin
          w_pix_nxt       = arb_bus.ctrl_rdata;
          w_pix_valid_nxt = 1'b1;
        end else if (w_timeout) begin
          w_err_nxt = 1'b1;
        end else begin
          w_wait_nxt = r_wait + WAIT_W'(1);
        end
      end
      WRITE: begin
        if (arb_bus.ctrl_ready) begin
          w_done_nxt = NUM_WR'(1) << r_sel;
          w_ptr_nxt  = w_ptr_adv;
        end else if (w_timeout) begin
          w_err_nxt = 1'b1;
          w_ptr_nxt = w_ptr_adv;
        end else begin
          w_wait_nxt = r_wait + WAIT_W'(1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_start_n   <= 1'b1;
      r_rw        <= RW_READ;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_pix_data  <= '0;
      r_pix_valid <= 1'b0;
      r_grant     <= '0;
      r_done      <= '0;
      r_busy      <= 1'b0;
      r_err       <= 1'b0;
      r_ptr       <= '0;
      r_sel       <= '0;
      r_wait      <= '0;
    end else begin
      r_start_n   <= w_start_n_nxt;
      r_rw        <= w_rw_nxt;
      r_addr      <= w_addr_nxt;
      r_wdata     <= w_wdata_nxt;
      r_pix_data  <= w_pix_nxt;
      r_pix_valid <= w_pix_valid_nxt;
      r_grant     <= w_grant_nxt;
      r_done      <= w_done_nxt;
      r_busy      <= (w_state_nxt != IDLE);
      r_err       <= w_err_nxt;
      r_ptr       <= w_ptr_nxt;
      r_sel       <= w_sel_nxt;
      r_wait      <= w_wait_nxt;
    end
  end

  assign arb_bus.ctrl_start_n = r_start_n;
  assign arb_bus.ctrl_rw      = r_rw;
  assign arb_bus.ctrl_addr    = r_addr;
  assign arb_bus.ctrl_wdata   = r_wdata;
  assign arb_bus.pix_data     = r_pix_data;
  assign arb_bus.pix_valid    = r_pix_valid;
  assign arb_bus.wr_grant     = r_grant;
  assign arb_bus.wr_done      = r_done;
  assign arb_bus.busy         = r_busy;
  assign arb_bus.err          = r_err;

endmodule
